// File: rtl/dispatch_ctrl.sv
// Instruction queue between fetcher and decoder: buffers fetched instructions and
// releases the head only when the ROB and its target station (RS or LSB) have room.
module dispatch_ctrl #(
    parameter int IQ_DEPTH = 16,
    parameter int IQ_PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_fetcher_valid,
    input  logic [31:0] in_fetcher_instr,
    input  logic [31:0] in_fetcher_pc,
    input  logic        in_fetcher_jump_flag,
    output logic        out_fetcher_full,
    input  logic        in_rob_full,
    input  logic        in_rs_full,
    input  logic        in_lsb_full,
    input  logic        in_rob_rollback,
    output logic        out_dec_valid,
    output logic [31:0] out_dec_instr,
    output logic [31:0] out_dec_pc,
    output logic        out_dec_jump_flag,
    output logic [31:0] out_stall_cnt
);

    localparam logic [6:0]          OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]          OPC_STORE  = 7'b0100011;
    localparam logic [IQ_PTR_W:0]   FULL_COUNT = (IQ_PTR_W + 1)'(IQ_DEPTH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    logic [IQ_PTR_W-1:0] r_head;
    logic [IQ_PTR_W-1:0] r_tail;
    logic [IQ_PTR_W:0]   r_count;
    logic [31:0]         r_stall_cnt;

    logic [31:0] r_instr_mem [IQ_DEPTH];
    logic [31:0] r_pc_mem    [IQ_DEPTH];
    logic        r_jf_mem    [IQ_DEPTH];

    logic        w_full;
    logic [31:0] w_head_instr;
    logic        w_to_lsb;
    logic        w_res_block;
    logic        w_active;
    logic        w_dispatch;
    logic        w_enq;
    logic        w_stall;

    assign w_full       = (r_count == FULL_COUNT) | (r_state == ST_FLUSH);
    assign w_head_instr = r_instr_mem[r_head];
    assign w_to_lsb     = (w_head_instr[6:0] == OPC_LOAD) | (w_head_instr[6:0] == OPC_STORE);
    assign w_res_block  = in_rob_full | (w_to_lsb ? in_lsb_full : in_rs_full);
    assign w_active     = rdy & (r_state == ST_RUN) & (r_count != '0);
    // A rollback cycle neither accepts nor releases anything: the queue is being discarded.
    assign w_dispatch   = w_active & ~w_res_block & ~in_rob_rollback;
    assign w_enq        = rdy & in_fetcher_valid & ~w_full & ~in_rob_rollback;
    assign w_stall      = w_active & w_res_block;

    // NOTE: storage arrays carry no reset; validity is tracked solely by head/tail/count,
    // so resetting the data would only cost flops and reset routing.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_instr_mem[r_tail] <= in_fetcher_instr;
            r_pc_mem[r_tail]    <= in_fetcher_pc;
            r_jf_mem[r_tail]    <= in_fetcher_jump_flag;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_stall_cnt <= '0;
        end else if (rdy) begin
            case (r_state)
                ST_RUN: begin
                    if (in_rob_rollback) begin
                        r_head  <= '0;
                        r_tail  <= '0;
                        r_count <= '0;
                        r_state <= ST_FLUSH;
                    end else begin
                        if (w_enq)      r_tail <= r_tail + 1'b1;
                        if (w_dispatch) r_head <= r_head + 1'b1;
                        if (w_enq & ~w_dispatch)      r_count <= r_count + 1'b1;
                        else if (~w_enq & w_dispatch) r_count <= r_count - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (!in_rob_rollback) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase

            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_fetcher_full  = w_full;
    assign out_dec_valid     = w_dispatch;
    assign out_dec_instr     = w_dispatch ? w_head_instr : '0;
    assign out_dec_pc        = w_dispatch ? r_pc_mem[r_head] : '0;
    assign out_dec_jump_flag = w_dispatch & r_jf_mem[r_head];
    assign out_stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based model of the dispatch rules.
module tb_dispatch_ctrl;

    localparam int DEPTH = 16;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst, rdy, fv, fjf, rob_f, rs_f, lsb_f, rb;
    logic [31:0] finstr, fpc;
    logic        ffull, dv, djf;
    logic [31:0] di, dp, sc;

    always #5 clk = ~clk;

    dispatch_ctrl #(.IQ_DEPTH(DEPTH), .IQ_PTR_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_fetcher_valid(fv), .in_fetcher_instr(finstr), .in_fetcher_pc(fpc),
        .in_fetcher_jump_flag(fjf), .out_fetcher_full(ffull),
        .in_rob_full(rob_f), .in_rs_full(rs_f), .in_lsb_full(lsb_f),
        .in_rob_rollback(rb),
        .out_dec_valid(dv), .out_dec_instr(di), .out_dec_pc(dp),
        .out_dec_jump_flag(djf), .out_stall_cnt(sc)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        jf;
    } ent_t;

    // Reference model: a FIFO of pending instructions, a flush flag and a stall tally.
    ent_t        iq[$];
    bit          flushing;
    logic [31:0] stall_m;
    logic [31:0] pc_seq;

    int          compared   = 0;
    int          mismatched = 0;
    logic [98:0] exp_obs;
    wire  [98:0] obs = {dv, di, dp, djf, ffull, sc};

    function automatic logic [31:0] mk_instr(input logic [6:0] op);
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], op};
    endfunction

    function automatic bit head_blocked();
        bit to_lsb;
        if (iq.size() == 0) return rob_f;
        to_lsb = (iq[0].instr[6:0] == OP_LW) || (iq[0].instr[6:0] == OP_SW);
        return rob_f || (to_lsb ? lsb_f : rs_f);
    endfunction

    function automatic bit will_dispatch();
        return rst && rdy && !flushing && iq.size() != 0 && !head_blocked() && !rb;
    endfunction

    task automatic model_reset();
        iq.delete();
        flushing = 0;
        stall_m  = '0;
    endtask

    task automatic expect_now();
        ent_t h;
        h = '0;
        if (will_dispatch()) h = iq[0];
        exp_obs = {will_dispatch(), h.instr, h.pc, h.jf,
                   (iq.size() == DEPTH) || flushing, stall_m};
    endtask

    task automatic drive(input bit v, input logic [6:0] op, input bit rob, input bit rs,
                         input bit lsb, input bit r_b, input bit rd);
        fv     = v;
        finstr = mk_instr(op);
        fpc    = pc_seq;
        fjf    = 1'($urandom_range(0, 1));
        rob_f  = rob;
        rs_f   = rs;
        lsb_f  = lsb;
        rb     = r_b;
        rdy    = rd;
        pc_seq = pc_seq + 32'd4;
    endtask

    // Advance one clock edge, applying the queue rules to the model with pre-edge inputs.
    task automatic step();
        bit ok, full, blk;
        int n;
        ok   = will_dispatch();
        full = (iq.size() == DEPTH) || flushing;
        blk  = head_blocked();
        n    = iq.size();
        @(posedge clk);
        if (rst && rdy) begin
            if (!flushing && n != 0 && blk && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
            if (rb) begin
                iq.delete();
                flushing = 1;
            end else if (flushing) begin
                flushing = 0;
            end else begin
                if (ok) void'(iq.pop_front());
                if (fv && !full) iq.push_back('{instr: finstr, pc: fpc, jf: fjf});
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, OP_ADDI, 0, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (obs !== 99'd0) begin
            mismatched++;
            $display("FAIL reset: got %h want 0", obs);
        end
        rst = 1'b1;
        #1;
        expect_now();
        compared++;
        if (obs !== exp_obs) begin
            mismatched++;
            $display("FAIL reset_release: got %h want %h", obs, exp_obs);
        end
        step();
    endtask

    task automatic test_in_order();
        logic [6:0] ops [3];
        ops = '{OP_ADDI, OP_LW, OP_SW};
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, ops[i % 3], 0, 0, 0, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL in_order cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 38; i++) begin
            if (i < 18) drive(1, 7'($urandom()), 1, 0, 0, 0, 1);
            else        drive(0, OP_ADD, 0, 0, 0, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL fill cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_lsb_block();
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, OP_LW, 0, 0, i < 4, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL lsb_block cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_rs_block();
        for (int i = 0; i < 7; i++) begin
            drive(i < 2, (i == 0) ? OP_ADD : OP_SW, 0, i < 4, 0, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL rs_block cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 14; i++) begin
            if (i < 8)        drive(1, OP_ADDI, 1, 0, 0, 0, 1);
            else if (i == 8)  drive(1, OP_ADDI, 0, 0, 0, 1, 1);
            else if (i <= 10) drive(1, OP_SW, 0, 0, 0, 0, 1);
            else              drive(0, OP_ADD, 0, 0, 0, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL rollback cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_rdy_freeze();
        for (int i = 0; i < 18; i++) begin
            if (i < 4)       drive(1, OP_LW, 1, 0, 0, 0, 1);
            else if (i < 9)  drive(1, OP_ADD, 0, 0, 0, 0, 0);
            else if (i < 12) drive(1, OP_ADDI, 0, 0, 0, 0, 1);
            else             drive(0, OP_ADDI, 0, 0, 0, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL rdy_freeze cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [4];
        ops = '{OP_ADDI, OP_LW, OP_SW, OP_ADD};
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) != 0, ops[$urandom_range(0, 3)],
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 7) != 0);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_ADDI, 1, 0, 0, 0, 1);
            step();
        end
        drive(0, OP_ADDI, 0, 0, 0, 0, 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        expect_now();
        compared++;
        if (obs !== exp_obs || obs !== 99'd0) begin
            mismatched++;
            $display("FAIL async_reset: got %h want %h", obs, exp_obs);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, OP_SW, 0, 0, 0, 0, 1);
            #1;
            expect_now();
            compared++;
            if (obs !== exp_obs) begin
                mismatched++;
                $display("FAIL post_reset cyc%0d: got %h want %h", i, obs, exp_obs);
            end
            step();
        end
    endtask

    initial begin
        pc_seq = 32'h0000_1000;
        test_reset();
        test_in_order();
        test_fill();
        test_lsb_block();
        test_rs_block();
        test_rollback();
        test_rdy_freeze();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
